// File: rtl/frame_cfg_pkg.sv
// Shared types and helpers for the column frame-strobe sequencer and the
// row frame-data register.
package frame_cfg_pkg;

    localparam int unsigned DefMaxFramesPerCol = 20;
    localparam int unsigned DefFrameIdxBits    = 5;
    localparam int unsigned DefColBits         = 5;
    localparam int unsigned AddrWidth          = DefColBits + DefFrameIdxBits;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_e;

    // One-hot frame select for the default column geometry; zero when out of range.
    function automatic logic [DefMaxFramesPerCol-1:0] onehot_frame(
        input logic [DefFrameIdxBits-1:0] index
    );
        logic [DefMaxFramesPerCol-1:0] r;
        r = '0;
        for (int i = 0; i < DefMaxFramesPerCol; i++) begin
            r[i] = (32'(index) == 32'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_cfg_pkg_addr_decode.sv
// Combinational frame-address decode: column match, index range check and
// one-hot frame select. Also used by the row frame-data register.
module frame_addr_decode #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameIdxBits    = 5,
    parameter int unsigned ColBits         = 5,
    parameter int unsigned ColumnSelect    = 0
) (
    input  logic [ColBits+FrameIdxBits-1:0] addr,
    output logic                            col_match,
    output logic                            in_range,
    output logic [MaxFramesPerCol-1:0]      onehot
);

    logic [FrameIdxBits-1:0] index;
    logic [ColBits-1:0]      col;

    assign index = addr[FrameIdxBits-1:0];
    assign col   = addr[ColBits+FrameIdxBits-1:FrameIdxBits];

    // Decode column, range and one-hot select; out-of-range indices give all zeros.
    always_comb begin
        col_match = (col == ColBits'(ColumnSelect));
        in_range  = (32'(index) < MaxFramesPerCol);
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            onehot[i] = (32'(index) == 32'(i));
        end
    end

endmodule

// File: rtl/frame_strobe_seq.sv
// Per-column FrameStrobe sequencer: accepts frame addresses, and for this
// column's in-range frames emits a setup window, a timed one-hot strobe and a
// one-cycle zero gap.
module frame_strobe_seq
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = DefMaxFramesPerCol,
    parameter int unsigned FrameIdxBits    = DefFrameIdxBits,
    parameter int unsigned ColBits         = DefColBits,
    parameter int unsigned ColumnSelect    = 0,
    parameter int unsigned SetupCycles     = 1,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                            UserCLK,
    input  logic                            rst,
    input  logic                            frame_addr_valid,
    output logic                            frame_addr_ready,
    input  logic [ColBits+FrameIdxBits-1:0] frame_addr,
    input  logic                            err_clr,
    output logic [MaxFramesPerCol-1:0]      FrameStrobe,
    output logic                            busy,
    output logic                            strobe_done,
    output logic                            err_range
);

    localparam int unsigned AW     = ColBits + FrameIdxBits;
    localparam int unsigned CntMax = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
    localparam int unsigned CntW   = ($clog2(CntMax + 1) < 1) ? 1 : $clog2(CntMax + 1);

    localparam int unsigned SetupLoadI  = (SetupCycles > 0) ? SetupCycles - 1 : 0;
    localparam int unsigned StrobeLoadI = (StrobeCycles > 0) ? StrobeCycles - 1 : 0;
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SetupLoadI);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeLoadI);

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [AW-1:0]             addr_q;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                      err_q, err_d;

    logic                      transfer;
    logic [AW-1:0]             dec_addr;
    logic                      dec_match;
    logic                      dec_in_range;
    logic [MaxFramesPerCol-1:0] dec_onehot;

    assign transfer = frame_addr_valid && (state_q == IDLE);
    // The live address is decoded on the accept edge; afterwards the held copy.
    assign dec_addr = transfer ? frame_addr : addr_q;

    frame_addr_decode #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .FrameIdxBits    (FrameIdxBits),
        .ColBits         (ColBits),
        .ColumnSelect    (ColumnSelect)
    ) u_decode (
        .addr      (dec_addr),
        .col_match (dec_match),
        .in_range  (dec_in_range),
        .onehot    (dec_onehot)
    );

    // State, counter and datapath registers.
    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            if (transfer) begin
                addr_q <= frame_addr;
            end
        end
    end

    // Next-state, counter and registered-strobe logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (transfer && dec_match && dec_in_range) begin
                    if (SetupCycles == 0) begin
                        state_d = STROBE;
                        cnt_d   = StrobeLoad;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SetupLoad;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        strobe_d = (state_d == STROBE) ? dec_onehot : '0;

        // A new range error wins over a same-cycle clear.
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (transfer && dec_match && !dec_in_range) begin
            err_d = 1'b1;
        end
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        frame_addr_ready = (state_q == IDLE);
        busy             = (state_q != IDLE);
        strobe_done      = (state_q == GAP);
        FrameStrobe      = strobe_q;
        err_range        = err_q;
    end

endmodule

// File: tb/tb_frame_strobe_seq.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// timeline model of the sequencer.
module tb_frame_strobe_seq;

    localparam int unsigned NF  = 20;
    localparam int unsigned COL = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Instance A: default timing. Instance B: no setup, one-cycle strobe.
    logic        a_valid, a_ready, a_clr, a_busy, a_done, a_err;
    logic [9:0]  a_addr;
    logic [19:0] a_strobe;
    logic        b_valid, b_ready, b_clr, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [19:0] b_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_strobe_seq #(
        .ColumnSelect (COL),
        .SetupCycles  (1),
        .StrobeCycles (2)
    ) dut_a (
        .UserCLK          (clk),
        .rst              (rst),
        .frame_addr_valid (a_valid),
        .frame_addr_ready (a_ready),
        .frame_addr       (a_addr),
        .err_clr          (a_clr),
        .FrameStrobe      (a_strobe),
        .busy             (a_busy),
        .strobe_done      (a_done),
        .err_range        (a_err)
    );

    frame_strobe_seq #(
        .ColumnSelect (COL),
        .SetupCycles  (0),
        .StrobeCycles (1)
    ) dut_b (
        .UserCLK          (clk),
        .rst              (rst),
        .frame_addr_valid (b_valid),
        .frame_addr_ready (b_ready),
        .frame_addr       (b_addr),
        .err_clr          (b_clr),
        .FrameStrobe      (b_strobe),
        .busy             (b_busy),
        .strobe_done      (b_done),
        .err_range        (b_err)
    );

    function automatic logic [19:0] oh(input int idx);
        logic [19:0] r;
        r = '0;
        if (idx >= 0 && idx < NF) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [9:0] mk(input int col, input int idx);
        return {5'(col), 5'(idx)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({a_strobe, a_busy, a_done, a_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_a: got strobe=%h busy=%b done=%b err=%b, want all 0",
                     a_strobe, a_busy, a_done, a_err);
        end
        n_checks++;
        if ({b_strobe, b_busy, b_done, b_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_b: got strobe=%h busy=%b done=%b err=%b, want all 0",
                     b_strobe, b_busy, b_done, b_err);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got a=%b b=%b, want 1 1", a_ready, b_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [19:0] es;
        a_addr  = mk(COL, 7);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_addr  = mk(COL, 2);  // ignored while busy
        for (int k = 1; k <= 5; k++) begin
            es = (k == 2 || k == 3) ? 20'h00080 : 20'h0;
            n_checks++;
            if (a_strobe !== es || a_ready !== (k == 5) || a_done !== (k == 4)
                || a_busy !== (k != 5)) begin
                n_fail++;
                $display("FAIL basic_k%0d: got strobe=%h rdy=%b done=%b busy=%b, want %h %b %b %b",
                         k, a_strobe, a_ready, a_done, a_busy, es, k == 5, k == 4, k != 5);
            end
            if (k < 5) tick();
        end
    endtask

    task automatic test_col_mismatch();
        a_addr  = mk(4, 7);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_strobe !== 20'h0 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_err !== 1'b0) begin
                n_fail++;
                $display("FAIL mismatch_k%0d: got strobe=%h busy=%b rdy=%b err=%b, want 0 0 1 0",
                         k, a_strobe, a_busy, a_ready, a_err);
            end
            tick();
        end
    endtask

    task automatic test_err_range();
        a_addr  = mk(COL, 20);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        n_checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_strobe !== 20'h0) begin
            n_fail++;
            $display("FAIL err_idx20: got err=%b busy=%b strobe=%h, want 1 0 0",
                     a_err, a_busy, a_strobe);
        end
        a_addr  = mk(COL, 31);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_strobe !== 20'h0) begin
            n_fail++;
            $display("FAIL err_idx31_sticky: got err=%b busy=%b strobe=%h, want 1 0 0",
                     a_err, a_busy, a_strobe);
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n_checks++;
        if (a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b, want 0", a_err);
        end
        a_addr  = mk(COL, 25);
        a_valid = 1'b1;
        a_clr   = 1'b1;
        tick();
        a_valid = 1'b0;
        a_clr   = 1'b0;
        n_checks++;
        if (a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_over_clr: got err=%b, want 1", a_err);
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int idx_list[3];
        int f;
        int ph;
        logic [19:0] es;
        idx_list[0] = 0;
        idx_list[1] = 1;
        idx_list[2] = 19;
        b_addr  = mk(COL, idx_list[0]);
        b_valid = 1'b1;
        tick();
        for (int j = 0; j < 9; j++) begin
            f  = j / 3;
            ph = j % 3;
            es = (ph == 0) ? oh(idx_list[f]) : 20'h0;
            n_checks++;
            if (b_strobe !== es || b_done !== (ph == 1) || b_ready !== (ph == 2)) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got strobe=%h done=%b rdy=%b, want %h %b %b",
                         j, b_strobe, b_done, b_ready, es, ph == 1, ph == 2);
            end
            if (ph == 2) begin
                if (f < 2) b_addr = mk(COL, idx_list[f + 1]);
                else b_valid = 1'b0;
            end
            tick();
        end
        b_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        a_addr  = mk(COL, 5);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (a_strobe !== oh(5)) begin
            n_fail++;
            $display("FAIL midrst_pre: got strobe=%h, want %h", a_strobe, oh(5));
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_strobe !== 20'h0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got strobe=%h busy=%b done=%b, want 0 0 0",
                     a_strobe, a_busy, a_done);
        end
        tick();
        n_checks++;
        if (a_done !== 1'b0 || a_strobe !== 20'h0) begin
            n_fail++;
            $display("FAIL midrst_hold: got done=%b strobe=%h, want 0 0", a_done, a_strobe);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: got rdy=%b done=%b, want 1 0", a_ready, a_done);
        end
        tick();
        a_addr  = mk(COL, 9);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (a_strobe !== ((k == 2 || k == 3) ? oh(9) : 20'h0) || a_done !== (k == 4)) begin
                n_fail++;
                $display("FAIL midrst_next_k%0d: got strobe=%h done=%b", k, a_strobe, a_done);
            end
            tick();
        end
    endtask

    // Timeline model: a frame accepted on edge acc occupies cycles acc..acc+S+St,
    // strobing during acc+S..acc+S+St-1 and signalling done at acc+S+St.
    task automatic test_random();
        localparam int S  = 1;
        localparam int ST = 2;
        int acc = -1000;
        int midx = 0;
        logic merr = 1'b0;
        int off;
        logic e_busy, e_done, e_ready, nerr;
        logic [19:0] e_strobe;
        logic [23:0] exp_v, act_v;
        int col, idx;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        for (int c = 0; c < 10000; c++) begin
            off      = c - acc;
            e_busy   = (off >= 0 && off <= S + ST);
            e_done   = (off == S + ST);
            e_strobe = (off >= S && off < S + ST) ? oh(midx) : 20'h0;
            e_ready  = !e_busy;
            exp_v    = {e_ready, e_busy, e_done, merr, e_strobe};
            act_v    = {a_ready, a_busy, a_done, a_err, a_strobe};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL rand_c%0d: got rdy/busy/done/err/strobe=%h, want %h",
                         c, act_v, exp_v);
            end
            n_checks++;
            if ($countones(a_strobe) > 1) begin
                n_fail++;
                $display("FAIL rand_onehot_c%0d: got strobe=%h, want at most one bit", c, a_strobe);
            end
            col     = ($urandom_range(0, 9) < 7) ? COL : $urandom_range(0, 31);
            idx     = $urandom_range(0, 31);
            a_addr  = mk(col, idx);
            a_valid = ($urandom_range(0, 9) < 6);
            a_clr   = ($urandom_range(0, 9) == 0);
            nerr    = a_clr ? 1'b0 : merr;
            if (a_valid && e_ready && col == COL) begin
                if (idx < NF) begin
                    acc  = c + 1;
                    midx = idx;
                end else begin
                    nerr = 1'b1;
                end
            end
            tick();
            merr = nerr;
        end
        a_valid = 1'b0;
        a_clr   = 1'b0;
    endtask

    initial begin
        a_valid = 1'b0;
        a_addr  = '0;
        a_clr   = 1'b0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_clr   = 1'b0;
        test_reset();
        test_basic();
        test_col_mismatch();
        test_err_range();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_strobe_seq.md
Name: frame_strobe_seq

Overview:
- Per-column configuration sequencer driving the FrameStrobe bus at the bottom of a fabric column.
- The bus ripples up through each tile's strobe buffers and ends at the north terminal tile.
- Accepts frame addresses from the configuration controller over a valid/ready handshake and decodes this column's matches into a timed one-hot strobe pulse.
- The pulse is framed by a setup window, so FrameData is stable before the write, and by a zero gap between frames.

Parameters:
- MaxFramesPerCol, 20, width of FrameStrobe; number of frames per column.
- FrameIdxBits, 5, width of the frame-index field (≥ clog2(MaxFramesPerCol)).
- ColBits, 5, width of the column-select field.
- ColumnSelect, 0, this column's index; compared against the column field.
- SetupCycles, 1, idle cycles between accept and strobe assertion (0 allowed).
- StrobeCycles, 2, cycles the one-hot strobe is held high (≥1).

Ports:
- UserCLK  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_addr_valid  input  1  address offered.
- frame_addr_ready  output  1  sequencer can accept.
- frame_addr  input  ColBits+FrameIdxBits  {column, frame index}; column in MSBs.
- err_clr  input  1  clears err_range.
- FrameStrobe  output  MaxFramesPerCol  one-hot column strobe; registered.
- busy  output  1  high in any state other than IDLE.
- strobe_done  output  1  single-cycle pulse after each completed frame.
- err_range  output  1  sticky: a matching address carried index ≥ MaxFramesPerCol.

Behaviour:
- Reset (rst=0, async): state=IDLE, FrameStrobe=0, busy=0, strobe_done=0, err_range=0, counters=0. frame_addr_ready=1 once rst deasserts.
- frame_addr_ready = (state==IDLE). Transfer occurs on an edge with valid&&ready. The address is registered on that transfer.
- Column field ≠ ColumnSelect: address dropped. State stays IDLE, no strobe, ready stays 1.
- Column matches and index ≥ MaxFramesPerCol: err_range set next cycle. No strobe; state stays IDLE.
- Column matches and index in range: go to SETUP, or straight to STROBE if SetupCycles=0.
- SETUP: down-counter loaded with SetupCycles−1; FrameStrobe=0; exit to STROBE when the counter reaches 0.
- STROBE: FrameStrobe = 1<<index for exactly StrobeCycles cycles; counter loaded with StrobeCycles−1.
- GAP: exactly one cycle with FrameStrobe=0. strobe_done pulses during GAP. Return to IDLE.
- Latency, accept edge to first strobe-high cycle: SetupCycles+1 cycles.
- Throughput: one frame per SetupCycles+StrobeCycles+2 cycles. Back-to-back valid is accepted on the first IDLE cycle after GAP.
- FrameStrobe never has more than one bit set, and never holds the same bit across two accepted frames without an intervening zero cycle.
- err_range: set has priority over a same-cycle err_clr. Otherwise err_clr clears it.
- rst asserted mid-SETUP/STROBE: FrameStrobe drops to 0 asynchronously. The in-flight frame is lost and strobe_done is not pulsed.
- Counter widths: clog2 of max(SetupCycles, StrobeCycles)+1, minimum 1. No wrap; counters only load or decrement to 0.
- frame_addr changes while busy are ignored; the registered copy is used.

Decomposition:
- Package frame_cfg_pkg:
  - state enum {IDLE, SETUP, STROBE, GAP};
  - localparam for address width (ColBits+FrameIdxBits);
  - function onehot_frame(index) returning MaxFramesPerCol bits, zero if out of range.
- One natural sub-module: frame_addr_decode. It is combinational: column match, range check, one-hot generation. It is shared with the future row frame-data register.
- FSM and counters stay in the top module.

Test Plan:
- Defaults, ColumnSelect=3; send {col=3, idx=7} → ready drops next cycle; FrameStrobe=0x00080 from cycle +2 for 2 cycles; zero 1 cycle with strobe_done=1; ready=1 at cycle +5.
- Send {col=4, idx=7} → no strobe, busy stays 0, ready stays 1, err_range=0.
- Send {col=3, idx=20}, then {col=3, idx=31} → err_range=1 and stays; no strobe. Pulse err_clr → 0. err_clr coincident with a new bad index → remains 1.
- SetupCycles=0, StrobeCycles=1; hold valid for idx 0,1,19 → strobes 0x00001, 0x00002, 0x80000, each 1 cycle starting the cycle after accept, with one zero cycle between; 3 cycles per frame.
- Assert rst during the second STROBE cycle of idx 5 → FrameStrobe=0 before the next edge; no strobe_done; after release, ready=1 and the next frame strobes normally.
- Random valid/col/idx for 10k cycles, checked against a scoreboard → one-hot invariant, zero gap between frames, exact latencies, and no accepts while busy.
